// File: rtl/rider_seq_pkg.sv
// Shared types and constants for the rider power/presence sequencer.
package rider_seq_pkg;

    // Sequencer states, in power-up order.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        SETTLE = 2'd2,
        STEER  = 2'd3
    } seq_state_t;

    // Summed load (both platforms) above which a rider counts as present.
    localparam logic [11:0] MIN_RIDER_WT_DEF = 12'h200;
    // Dismount threshold sits this far below the presence threshold.
    localparam logic [11:0] WT_HYST_DEF      = 12'h040;

    // Settle timer: full width for silicon, short window for simulation.
    localparam int TMR_W      = 26;
    localparam int TMR_W_FAST = 15;

    // Observation port: current state and overspeed run length.
    typedef struct packed {
        seq_state_t state;
        logic [1:0] ovr_cnt;
    } seq_dbg_t;

    // Magnitude of the left/right load imbalance.
    function automatic logic [11:0] abs_diff(input logic [11:0] a, input logic [11:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/rider_seq_settle.sv
// Settle timer: counts cycles of a steady rider while the sequencer is settling.
module settle_tmr
    import rider_seq_pkg::*;
#(
    parameter bit fast_sim = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tmr_full
);

    logic [TMR_W-1:0] cnt;

    // Clear wins over count so a restart never leaks an old count forward.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Terminal count: all-ones in the low 15 bits (fast) or all 26 bits.
    always_comb begin
        if (fast_sim) begin
            tmr_full = &cnt[TMR_W_FAST-1:0];
        end else begin
            tmr_full = &cnt;
        end
    end

endmodule

// File: rtl/rider_seq.sv
// Power and rider-presence sequencer in front of the balance controller.
// Holds PID integration and steering off until a rider is on, balanced and
// settled, and backs steering off on step-off or sustained overspeed.
//
// vld is a plain one-cycle strobe (no ready/back-pressure): every cycle it is
// high counts as one inertial sample, so a level held for k cycles counts k times.
module rider_seq
    import rider_seq_pkg::*;
#(
    parameter bit          fast_sim     = 1'b1,
    parameter logic [11:0] MIN_RIDER_WT = MIN_RIDER_WT_DEF,
    parameter logic [11:0] WT_HYST      = WT_HYST_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pwr_req,
    input  logic [11:0] lft_ld,
    input  logic [11:0] rght_ld,
    input  logic        vld,
    input  logic        too_fast,
    output logic        pwr_up,
    output logic        rider_off,
    output logic        en_steer,
    output seq_dbg_t    dbg
);

    seq_state_t state;
    seq_state_t nxt_state;

    logic [12:0] sum;
    logic [11:0] diff;
    logic [11:0] off_thr;
    logic        on_wt;
    logic        off_wt;
    logic        unbal;
    logic        stepoff;

    logic [1:0]  ovr_cnt;
    logic        ovr_trip;

    logic        tmr_clr;
    logic        tmr_en;
    logic        tmr_full;

    // Load-cell arithmetic; purely combinational from the inputs.
    always_comb begin
        sum     = {1'b0, lft_ld} + {1'b0, rght_ld};
        diff    = abs_diff(lft_ld, rght_ld);
        off_thr = MIN_RIDER_WT - WT_HYST;
        on_wt   = sum > {1'b0, MIN_RIDER_WT};
        off_wt  = sum < {1'b0, off_thr};
        unbal   = {1'b0, diff} > (sum >> 2);
        stepoff = {1'b0, diff} > (sum - (sum >> 4));
    end

    // Fourth consecutive overspeed sample while steering (counter already saturated).
    assign ovr_trip = (state == STEER) && vld && too_fast && (ovr_cnt == 2'd3);

    // Next-state and timer-clear decode. pwr_req is ignored once settling or
    // steering so power is never dropped under a rider.
    always_comb begin
        nxt_state = state;
        tmr_clr   = 1'b0;
        case (state)
            IDLE: begin
                if (pwr_req) begin
                    nxt_state = WAIT;
                end
            end
            WAIT: begin
                if (!pwr_req) begin
                    nxt_state = IDLE;
                end else if (on_wt && !unbal) begin
                    nxt_state = SETTLE;
                    tmr_clr   = 1'b1;
                end
            end
            SETTLE: begin
                if (off_wt) begin
                    nxt_state = WAIT;
                end else if (unbal) begin
                    tmr_clr = 1'b1;
                end else if (tmr_full) begin
                    nxt_state = STEER;
                end
            end
            STEER: begin
                if (off_wt) begin
                    nxt_state = WAIT;
                end else if (stepoff || ovr_trip) begin
                    nxt_state = SETTLE;
                    tmr_clr   = 1'b1;
                end
            end
            default: begin
                nxt_state = IDLE;
            end
        endcase
    end

    assign tmr_en = (state == SETTLE);

    settle_tmr #(
        .fast_sim (fast_sim)
    ) u_settle_tmr (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (tmr_clr),
        .en       (tmr_en),
        .tmr_full (tmr_full)
    );

    // State register with Moore outputs registered from the next state, so the
    // outputs always match the state register and never see an input directly.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            pwr_up    <= 1'b0;
            rider_off <= 1'b1;
            en_steer  <= 1'b0;
        end else begin
            state     <= nxt_state;
            pwr_up    <= (nxt_state != IDLE);
            rider_off <= (nxt_state == IDLE) || (nxt_state == WAIT);
            en_steer  <= (nxt_state == STEER);
        end
    end

    // Overspeed run counter: only live while staying in STEER, otherwise held at 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovr_cnt <= 2'd0;
        end else if ((state != STEER) || (nxt_state != STEER)) begin
            ovr_cnt <= 2'd0;
        end else if (vld) begin
            if (!too_fast) begin
                ovr_cnt <= 2'd0;
            end else if (ovr_cnt != 2'd3) begin
                ovr_cnt <= ovr_cnt + 2'd1;
            end
        end
    end

    // Debug view of the FSM for checkers.
    always_comb begin
        dbg.state   = state;
        dbg.ovr_cnt = ovr_cnt;
    end

endmodule

// File: tb/tb_rider_seq.sv
// Self-checking bench for rider_seq (fast_sim=1) with a cycle-level behavioural model.
module tb_rider_seq;
    import rider_seq_pkg::*;

    localparam int SETTLE_CYC = 1 << 15;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pwr_req = 1'b0;
    logic [11:0] lft_ld = 12'h0;
    logic [11:0] rght_ld = 12'h0;
    logic        vld = 1'b0;
    logic        too_fast = 1'b0;
    logic        pwr_up;
    logic        rider_off;
    logic        en_steer;
    seq_dbg_t    dbg;

    always #5 clk = ~clk;

    rider_seq #(
        .fast_sim (1'b1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pwr_req   (pwr_req),
        .lft_ld    (lft_ld),
        .rght_ld   (rght_ld),
        .vld       (vld),
        .too_fast  (too_fast),
        .pwr_up    (pwr_up),
        .rider_off (rider_off),
        .en_steer  (en_steer),
        .dbg       (dbg)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Model tracks: which phase the rider is in, how long the rider has been
    // steady while settling, and how many overspeed samples came in a row.
    seq_state_t m_state = IDLE;
    int         m_age   = 0;
    int         m_run   = 0;

    function automatic logic [2:0] outs_of(input seq_state_t s);
        case (s)
            IDLE:    return 3'b010;
            WAIT:    return 3'b110;
            SETTLE:  return 3'b100;
            default: return 3'b101;
        endcase
    endfunction

    task automatic model_step();
        int  s;
        int  d;
        bit  rider_on;
        bit  rider_gone;
        bit  lopsided;
        bit  stepped;
        if (!rst_n) begin
            m_state = IDLE;
            m_age   = 0;
            m_run   = 0;
            return;
        end
        s          = int'(lft_ld) + int'(rght_ld);
        d          = (lft_ld >= rght_ld) ? int'(lft_ld) - int'(rght_ld) : int'(rght_ld) - int'(lft_ld);
        rider_on   = s > 512;
        rider_gone = s < 512 - 64;
        lopsided   = d > s / 4;
        stepped    = d > s - s / 16;
        case (m_state)
            IDLE: if (pwr_req) m_state = WAIT;
            WAIT: begin
                if (!pwr_req) m_state = IDLE;
                else if (rider_on && !lopsided) begin
                    m_state = SETTLE;
                    m_age   = 0;
                end
            end
            SETTLE: begin
                if (rider_gone) m_state = WAIT;
                else if (lopsided) m_age = 0;
                else begin
                    m_age++;
                    if (m_age == SETTLE_CYC) begin
                        m_state = STEER;
                        m_run   = 0;
                    end
                end
            end
            default: begin
                if (vld) m_run = too_fast ? m_run + 1 : 0;
                if (rider_gone) begin
                    m_state = WAIT;
                    m_run   = 0;
                end else if (stepped || m_run >= 4) begin
                    m_state = SETTLE;
                    m_age   = 0;
                    m_run   = 0;
                end
            end
        endcase
    endtask

    // ---------------- driver tasks ----------------
    // One clock: model advances on the edge, DUT compared on the falling edge.
    task automatic tick();
        logic [6:0] got;
        logic [6:0] exp;
        logic [1:0] exp_ovr;
        @(posedge clk);
        model_step();
        @(negedge clk);
        exp_ovr = (m_state == STEER) ? 2'(m_run) : 2'd0;
        exp     = {m_state, exp_ovr, outs_of(m_state)};
        got     = {dbg.state, dbg.ovr_cnt, pwr_up, rider_off, en_steer};
        check("cycle", 32'(got), 32'(exp));
    endtask

    task automatic set_balanced();
        lft_ld  = 12'($urandom_range(12'h280, 12'h300));
        rght_ld = 12'($urandom_range(12'h280, 12'h300));
    endtask

    task automatic pulse(input logic tf);
        vld      = 1'b1;
        too_fast = tf;
        tick();
        vld      = 1'b0;
        too_fast = 1'b0;
        tick();
    endtask

    // Wait for en_steer with a cycle budget; returns cycles taken.
    task automatic wait_steer(output int n);
        n = 0;
        while (!en_steer && n < SETTLE_CYC + 200) begin
            set_balanced();
            tick();
            n++;
        end
    endtask

    task automatic random_loads();
        int total;
        case ($urandom_range(0, 3))
            0: begin
                lft_ld  = 12'($urandom_range(0, 12'h3FF));
                rght_ld = 12'($urandom_range(0, 12'h3FF));
            end
            1: begin
                case ($urandom_range(0, 3))
                    0: total = 'h1BF;
                    1: total = 'h1C0;
                    2: total = 'h200;
                    default: total = 'h201;
                endcase
                lft_ld  = 12'($urandom_range(0, total));
                rght_ld = 12'(total - int'(lft_ld));
            end
            2: set_balanced();
            default: begin
                lft_ld  = 12'($urandom_range(12'h300, 12'h400));
                rght_ld = 12'($urandom_range(0, 12'h080));
            end
        endcase
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        rst_n   = 1'b0;
        pwr_req = 1'b1;
        lft_ld  = 12'h300;
        rght_ld = 12'h300;
        @(negedge clk);

        // Reset held with a power request and a rider present.
        repeat (3) tick();
        check("rst_outs", 32'({pwr_up, rider_off, en_steer}), 32'(3'b010));
        check("rst_state", 32'(dbg.state), 32'(IDLE));
        check("rst_ovr", 32'(dbg.ovr_cnt), 32'd0);

        rst_n = 1'b1;
        tick();
        check("wait_c1", 32'(dbg.state), 32'(WAIT));
        tick();
        check("settle_c2", 32'(dbg.state), 32'(SETTLE));
        check("settle_rider_off", 32'(rider_off), 32'd0);
        n = 0;
        while (!en_steer && n < SETTLE_CYC + 200) begin
            tick();
            n++;
        end
        check("settle_len", 32'(n), 32'(SETTLE_CYC));

        // Power request dropped under a rider is ignored.
        pwr_req = 1'b0;
        repeat (4) tick();
        check("pwr_hold_state", 32'(dbg.state), 32'(STEER));
        check("pwr_hold_up", 32'(pwr_up), 32'd1);
        pwr_req = 1'b1;

        // Overspeed: 3 hot, 1 cool, then 4 hot trips on the 4th.
        for (int i = 0; i < 3; i++) pulse(1'b1);
        check("ovr_three_state", 32'(dbg.state), 32'(STEER));
        check("ovr_three_cnt", 32'(dbg.ovr_cnt), 32'd3);
        pulse(1'b0);
        check("ovr_clear", 32'(dbg.ovr_cnt), 32'd0);
        for (int i = 0; i < 3; i++) pulse(1'b1);
        check("ovr_second3", 32'(dbg.state), 32'(STEER));
        vld      = 1'b1;
        too_fast = 1'b1;
        tick();
        check("ovr_trip_state", 32'(dbg.state), 32'(SETTLE));
        check("ovr_trip_steer", 32'(en_steer), 32'd0);
        vld      = 1'b0;
        too_fast = 1'b0;

        // Settle again; imbalance at cycle 10000 restarts the settle window.
        for (int i = 0; i < 10000; i++) begin
            set_balanced();
            vld      = ($urandom_range(0, 3) == 0);
            too_fast = 1'($urandom_range(0, 1));
            tick();
        end
        vld      = 1'b0;
        too_fast = 1'b0;
        check("no_early_steer", 32'(en_steer), 32'd0);
        lft_ld  = 12'h380;
        rght_ld = 12'h100;
        tick();
        check("unbal_hold", 32'(dbg.state), 32'(SETTLE));
        wait_steer(n);
        check("unbal_delay", 32'(n), 32'(SETTLE_CYC));

        // Steering with random samples; overspeed run never reaches four.
        for (int i = 0; i < 200; i++) begin
            set_balanced();
            vld      = ($urandom_range(0, 2) == 0);
            too_fast = (m_run >= 3) ? 1'b0 : 1'($urandom_range(0, 1));
            tick();
        end
        check("steer_random_state", 32'(dbg.state), 32'(STEER));
        vld      = 1'b0;
        too_fast = 1'b0;

        // Step-off: one platform unloaded.
        lft_ld  = 12'h300;
        rght_ld = 12'h000;
        tick();
        check("stepoff_state", 32'(dbg.state), 32'(SETTLE));
        check("stepoff_steer", 32'(en_steer), 32'd0);
        check("stepoff_rider_off", 32'(rider_off), 32'd0);

        // Dismount with no power request: WAIT, then IDLE.
        lft_ld  = 12'h0C0;
        rght_ld = 12'h0C0;
        pwr_req = 1'b0;
        tick();
        check("off_state", 32'(dbg.state), 32'(WAIT));
        check("off_rider_off", 32'(rider_off), 32'd1);
        check("off_pwr_up", 32'(pwr_up), 32'd1);
        tick();
        check("idle_state", 32'(dbg.state), 32'(IDLE));
        check("idle_pwr_up", 32'(pwr_up), 32'd0);

        // Random threshold exploration outside STEER.
        for (int i = 0; i < 1500; i++) begin
            pwr_req  = ($urandom_range(0, 7) != 0);
            random_loads();
            vld      = 1'($urandom_range(0, 1));
            too_fast = 1'($urandom_range(0, 1));
            tick();
        end

        // Reset mid-operation with a rider settling and samples arriving.
        pwr_req = 1'b1;
        vld     = 1'b0;
        repeat (3) begin
            set_balanced();
            tick();
        end
        check("pre_rst_state", 32'(dbg.state), 32'(SETTLE));
        rst_n    = 1'b0;
        vld      = 1'b1;
        too_fast = 1'b1;
        tick();
        check("rst_mid_state", 32'(dbg.state), 32'(IDLE));
        check("rst_mid_outs", 32'({pwr_up, rider_off, en_steer}), 32'(3'b010));
        check("rst_mid_ovr", 32'(dbg.ovr_cnt), 32'd0);
        rst_n    = 1'b1;
        vld      = 1'b0;
        too_fast = 1'b0;
        pwr_req  = 1'b0;
        tick();
        check("post_rst_state", 32'(dbg.state), 32'(IDLE));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global time bound.
    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/rider_seq.md
# rider_seq

Power and rider-presence sequencer for the balance controller. It gates `pwr_up`, `rider_off` and `en_steer` into the balance controller from the authorization request and the two foot-platform load cells, which keeps PID integration and steering disabled until a rider is verifiably on and settled. It also backs steering off when the platform reports sustained overspeed. It sits between the authorization/A2D blocks and the balance controller.

## Interface
- `fast_sim`, 1, shortens the settle timer for simulation (2^15 cycles instead of 2^26)
- `MIN_RIDER_WT`, 12'h200, summed load above which a rider is present
- `WT_HYST`, 12'h040, hysteresis subtracted from `MIN_RIDER_WT` for the dismount test
- `clk`  in  1  system clock; the only clock domain
- `rst_n`  in  1  reset, synchronous and active-low
- `pwr_req`  in  1  level; authorization requests power-up
- `lft_ld`  in  12  left load cell, unsigned
- `rght_ld`  in  12  right load cell, unsigned
- `vld`  in  1  one-cycle strobe per new inertial sample
- `too_fast`  in  1  overspeed flag from the balance controller, sampled only on `vld`
- `pwr_up`  out  1  to balance controller
- `rider_off`  out  1  to balance controller; clears the PID integrator
- `en_steer`  out  1  to balance controller

## Operation
- Arithmetic, combinational from the inputs:
  - `sum = lft_ld + rght_ld`, 13 bit.
  - `diff = |lft_ld - rght_ld|`, 12 bit.
  - `on = sum > MIN_RIDER_WT`.
  - `off = sum < MIN_RIDER_WT - WT_HYST`.
  - `unbal = diff > sum>>2`.
  - `stepoff = diff > sum - (sum>>4)`.
- States and Moore outputs (`pwr_up`/`rider_off`/`en_steer`):
  - IDLE: 0/1/0.
  - WAIT: 1/1/0.
  - SETTLE: 1/0/0.
  - STEER: 1/0/1.
- State transitions:
  - IDLE -> WAIT when `pwr_req`=1.
  - WAIT -> IDLE when `pwr_req`=0. Otherwise WAIT -> SETTLE when `on && !unbal`. The settle timer clears on this transition.
  - SETTLE -> WAIT when `off`. The `off` test has priority over everything else in SETTLE.
  - SETTLE: `unbal` clears the timer and the state holds.
  - SETTLE -> STEER when the timer reaches terminal count.
  - STEER -> WAIT when `off`.
  - STEER -> SETTLE when `stepoff`, or on the 4th consecutive `vld` with `too_fast`=1. The timer clears on this transition.
- Settle timer:
  - 26-bit up-counter.
  - Advances only in SETTLE.
  - Terminal count is all-ones in bits [25:0] (`fast_sim`=0) or bits [14:0] (`fast_sim`=1).
- Overspeed counter:
  - 2-bit.
  - Increments on `vld && too_fast` while in STEER.
  - Clears on `vld && !too_fast` and whenever the state is not STEER.
  - Saturates at 3; the 4th qualifying `vld` triggers the STEER -> SETTLE transition.
- `pwr_req` deassertion while in SETTLE or STEER is ignored, so power is never dropped under a rider. After the rider dismounts, WAIT -> IDLE follows on the next cycle if `pwr_req` is still 0.
- Simultaneous events in STEER: `off` wins over `stepoff`/overspeed, so the next state is WAIT.
- `rst_n`=0 mid-operation:
  - Next edge forces IDLE, both counters to 0, outputs to 0/1/0.
  - Nothing is held over from before reset.

## Timing
- All outputs are registered and decoded from the state register. There is no combinational path from any input to any output.
- Latency: an input condition true at edge N gives the new outputs after edge N, i.e. visible in cycle N+1.
- Reset values: `pwr_up`=0, `rider_off`=1, `en_steer`=0, state IDLE, timer 0, overspeed counter 0.
- SETTLE -> STEER takes exactly 2^15 cycles after SETTLE entry (`fast_sim`=1), provided no `unbal` occurs.
- `vld` is a one-cycle pulse. A `vld` held high for k cycles counts k times, and this is the required behaviour.

## Structure
- Package `rider_seq_pkg` holds:
  - state enum `seq_state_t`: IDLE, WAIT, SETTLE, STEER;
  - `MIN_RIDER_WT` and `WT_HYST` defaults;
  - timer widths 26 and 15.
- Sub-module `settle_tmr` holds the counter, clear, enable, `fast_sim` parameter and `tmr_full` output.
- Load compare, overspeed counter and FSM live in the top.

## Test plan
- Reset with `pwr_req`=1, `lft_ld`=`rght_ld`=12'h300 -> during reset outputs 0/1/0. After release: WAIT in cycle 1, SETTLE in cycle 2, `en_steer`=1 exactly 2^15 cycles later.
- In SETTLE, `lft_ld`=12'h380 and `rght_ld`=12'h100 (diff 0x280 > sum>>2 = 0x120) at cycle 10000 -> timer clears. STEER entry is delayed to 2^15 cycles after the last unbalanced cycle.
- In STEER, `rght_ld` drops to 0 with `lft_ld`=12'h300 (stepoff) -> next cycle SETTLE, `en_steer`=0, `rider_off`=0.
- In STEER, both loads drop to 12'h0C0 (sum 0x180 < 0x1C0) -> WAIT, `rider_off`=1. With `pwr_req`=0 the following cycle goes to IDLE and `pwr_up`=0.
- In STEER, `pwr_req`=0 -> remains STEER, `pwr_up`=1. Then loads go to 0 -> WAIT, then IDLE on the next cycle.
- In STEER, `too_fast`=1 on 3 `vld` pulses, then 0 on 1 pulse, then 1 on 4 pulses -> stays STEER until the 4th pulse of the second burst, then SETTLE. Assert `rst_n`=0 mid-burst -> IDLE and counter 0 on the next edge.
